// File: rtl/acc_pkg.sv
// Shared constants and overflow-aware addition for the multi-channel accumulator.
// sat_add works on a wide container; the caller chooses the effective width.
package acc_pkg;

   localparam int DIN_WIDTH_DEF  = 32;
   localparam int DOUT_WIDTH_DEF = 32;
   localparam int SUM_W          = 128;

   typedef struct packed {
      logic signed [SUM_W-1:0] sum;
      logic                    ovf;
   } sat_add_t;

   // Adds two sign-extended operands and fits the result into 'width' signed bits,
   // clamping or wrapping as selected; ovf flags any departure from the true sum.
   function automatic sat_add_t sat_add(input logic signed [SUM_W-1:0] a,
                                        input logic signed [SUM_W-1:0] b,
                                        input int                      width,
                                        input logic                    saturate);
      logic signed [SUM_W:0] full;
      logic signed [SUM_W:0] one;
      logic signed [SUM_W:0] hi;
      logic signed [SUM_W:0] lo;
      logic signed [SUM_W:0] wrapped;
      sat_add_t              res;
      one     = (SUM_W+1)'(1);
      full    = {a[SUM_W-1], a} + {b[SUM_W-1], b};
      hi      = (one <<< (width - 1)) - one;
      lo      = -hi - one;
      wrapped = (full <<< (SUM_W + 1 - width)) >>> (SUM_W + 1 - width);
      res.ovf = (full > hi) || (full < lo);
      if (res.ovf && saturate)
         res.sum = (full > hi) ? hi[SUM_W-1:0] : lo[SUM_W-1:0];
      else
         res.sum = wrapped[SUM_W-1:0];
      return res;
   endfunction

endpackage

// File: rtl/acc_channel.sv
// One accumulator lane: signed running sum with sticky overflow flag,
// global clear, read-and-clear, and saturating or wrapping addition.
module acc_channel
   import acc_pkg::*;
#(
   parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
   parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         add_en,
   input  logic signed [DIN_WIDTH-1:0]  add_data,
   input  logic                         rd_clr,
   output logic signed [DOUT_WIDTH-1:0] acc,
   output logic                         ovf
);

   logic signed [SUM_W-1:0] data_ext;
   logic signed [SUM_W-1:0] acc_ext;
   sat_add_t                add_res;
   logic                    unused_hi;

   always_comb begin
      data_ext = SUM_W'(add_data);
      acc_ext  = SUM_W'(acc);
      add_res  = sat_add(acc_ext, data_ext, DOUT_WIDTH, SATURATE);
   end

   // Bits above DOUT_WIDTH are only sign copies of the fitted result.
   assign unused_hi = ^add_res.sum[SUM_W-1:DOUT_WIDTH];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc <= '0;
         ovf <= 1'b0;
      end else if (rd_clr) begin
         // A same-cycle sample starts the freshly cleared lane.
         if (add_en)
            acc <= DOUT_WIDTH'(add_data);
         else
            acc <= '0;
         ovf <= 1'b0;
      end else if (add_en) begin
         acc <= add_res.sum[DOUT_WIDTH-1:0];
         ovf <= ovf | add_res.ovf;
      end
   end

endmodule

// File: rtl/multi_channel_accumulator.sv
// NUM_CH independent signed accumulators with a shared one-cycle read port
// that returns pre-update channel state and can optionally clear the channel.
module multi_channel_accumulator
   import acc_pkg::*;
#(
   parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
   parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
   parameter int NUM_CH     = 4,
   parameter bit SATURATE   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_i,
   input  logic                          en_i,
   input  logic [$clog2(NUM_CH)-1:0]     ch_i,
   input  logic signed [DIN_WIDTH-1:0]   data_i,
   input  logic                          clear_i,
   input  logic                          rd_en_i,
   input  logic [$clog2(NUM_CH)-1:0]     rd_ch_i,
   input  logic                          rd_clr_i,
   output logic                          rd_valid_o,
   output logic signed [DOUT_WIDTH-1:0]  rd_data_o,
   output logic                          rd_ovf_o,
   output logic [NUM_CH-1:0]             ovf_o
);

   localparam int CH_W = $clog2(NUM_CH);

   logic signed [DOUT_WIDTH-1:0] acc [NUM_CH];
   logic [NUM_CH-1:0]            ovf;
   logic signed [DOUT_WIDTH-1:0] rd_data_p0;
   logic                         rd_ovf_p0;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic add_en;
      logic rd_clr;

      // Out-of-range channel codes match no lane and so are dropped.
      assign add_en = en_i && (ch_i == CH_W'(k));
      assign rd_clr = rd_en_i && rd_clr_i && (rd_ch_i == CH_W'(k));

      acc_channel #(
         .DIN_WIDTH  (DIN_WIDTH),
         .DOUT_WIDTH (DOUT_WIDTH),
         .SATURATE   (SATURATE)
      ) u_ch (
         .clk      (clk),
         .rst      (rst_i),
         .clear    (clear_i),
         .add_en   (add_en),
         .add_data (data_i),
         .rd_clr   (rd_clr),
         .acc      (acc[k]),
         .ovf      (ovf[k])
      );
   end

   assign ovf_o = ovf;

   always_comb begin
      rd_data_p0 = '0;
      rd_ovf_p0  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (rd_ch_i == CH_W'(k)) begin
            rd_data_p0 = acc[k];
            rd_ovf_p0  = ovf[k];
         end
      end
   end

   // Stage 1: registered read port, holds last result between requests
   always_ff @(posedge clk) begin
      if (rst_i) begin
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
         rd_ovf_o   <= 1'b0;
      end else begin
         rd_valid_o <= rd_en_i;
         if (rd_en_i) begin
            rd_data_o <= rd_data_p0;
            rd_ovf_o  <= rd_ovf_p0;
         end
      end
   end

endmodule
